// File: rtl/tx_keying_sequencer_pkg.sv
// tx_keying_sequencer_pkg: keying sequencer state encoding and sample width
package tx_keying_sequencer_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic [2:0] RX        = 3'd0;
  localparam logic [2:0] SETTLE    = 3'd1;
  localparam logic [2:0] RAMP_UP   = 3'd2;
  localparam logic [2:0] TX        = 3'd3;
  localparam logic [2:0] RAMP_DOWN = 3'd4;
  localparam logic [2:0] RELEASE   = 3'd5;
endpackage

// File: rtl/tx_keying_sequencer_ramp_gain_mult.sv
// ramp_gain_mult: registered I/Q gain scaling by gain/2^L on each sample strobe
module ramp_gain_mult
  import tx_keying_sequencer_pkg::*;
#(
  parameter int L = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [L:0]                 gain,
  input  logic signed [SAMPLE_W-1:0] real_in,
  input  logic signed [SAMPLE_W-1:0] imag_in,
  output logic signed [SAMPLE_W-1:0] real_out,
  output logic signed [SAMPLE_W-1:0] imag_out
);
  localparam int PW = SAMPLE_W + L + 1;
  logic signed [L+1:0] g;
  logic signed [PW-1:0] real_p, imag_p;
  assign g = {1'b0, gain};
  assign real_p = PW'(real_in) * PW'(g);
  assign imag_p = PW'(imag_in) * PW'(g);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      real_out <= '0;
      imag_out <= '0;
    end else if (en) begin
      real_out <= SAMPLE_W'(real_p >>> L);
      imag_out <= SAMPLE_W'(imag_p >>> L);
    end
endmodule

// File: rtl/tx_keying_sequencer.sv
// tx_keying_sequencer: RX/TX keying sequence with relay settle and linear baseband ramp
module tx_keying_sequencer
  import tx_keying_sequencer_pkg::*;
#(
  parameter int CLOCK_FREQ         = 153600000,
  parameter int RELAY_DELAY_CYCLES = CLOCK_FREQ / 200,
  parameter int RAMP_STEPS_LOG2    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_req,
  input  logic                       sample_stb,
  input  logic signed [SAMPLE_W-1:0] tx_real_in,
  input  logic signed [SAMPLE_W-1:0] tx_imag_in,
  output logic signed [SAMPLE_W-1:0] tx_real_out,
  output logic signed [SAMPLE_W-1:0] tx_imag_out,
  output logic                       tx_key,
  output logic                       pa_enable,
  output logic                       rx_mute,
  output logic                       busy
);
  localparam int L  = RAMP_STEPS_LOG2;
  localparam int CW = $clog2(RELAY_DELAY_CYCLES + 1);
  localparam logic [L:0] G_MAX = {1'b1, {L{1'b0}}};
  localparam logic [L:0] G_ONE = (L+1)'(1);
  localparam logic [CW-1:0] C_END = CW'(RELAY_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  logic key_m, key_s, active;
  logic [2:0] st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [L:0] gain, gain_n;
  assign active = st == RAMP_UP || st == TX || st == RAMP_DOWN;
  assign gain_n = !(active && sample_stb) ? gain :
                  key_s ? (gain == G_MAX ? gain : gain + G_ONE) :
                          (gain == '0 ? gain : gain - G_ONE);
  assign cnt_n = (st_n == st && (st == SETTLE || st == RELEASE)) ? cnt + C_ONE : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= key_req;
      key_s <= key_m;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st   <= RX;
      cnt  <= '0;
      gain <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      gain <= gain_n;
    end
  always_comb begin
    st_n = RX;
    case (st)
      RX:        st_n = key_s ? SETTLE : RX;
      SETTLE:    st_n = cnt == C_END ? (key_s ? RAMP_UP : RELEASE) : SETTLE;
      RAMP_UP:   st_n = !key_s ? RAMP_DOWN : gain_n == G_MAX ? TX : RAMP_UP;
      TX:        st_n = key_s ? TX : RAMP_DOWN;
      RAMP_DOWN: st_n = key_s ? RAMP_UP : gain_n == '0 ? RELEASE : RAMP_DOWN;
      RELEASE:   st_n = cnt == C_END ? RX : RELEASE;
      default:   st_n = RX;
    endcase
  end
  always_comb begin
    tx_key    = active;
    pa_enable = active || st == SETTLE;
    rx_mute   = st != RX;
    busy      = st != RX;
  end
  ramp_gain_mult #(.L(L)) u_mult (
    .clk      (clk),
    .reset    (reset),
    .en       (sample_stb),
    .gain     (active ? gain : '0),
    .real_in  (tx_real_in),
    .imag_in  (tx_imag_in),
    .real_out (tx_real_out),
    .imag_out (tx_imag_out)
  );
endmodule

// File: tb/tb_tx_keying_sequencer.sv
// tb_tx_keying_sequencer: directed self-checking bench for the keying sequencer
module tb_tx_keying_sequencer;
  logic clk = 1'b0;
  logic reset, key_req, sample_stb;
  logic signed [15:0] tx_real_in, tx_imag_in, tx_real_out, tx_imag_out;
  logic tx_key, pa_enable, rx_mute, busy;
  int errors = 0;
  int checks = 0;
  int phase = 0;

  always #5 clk = ~clk;

  tx_keying_sequencer #(
    .RELAY_DELAY_CYCLES (10),
    .RAMP_STEPS_LOG2    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_req     (key_req),
    .sample_stb  (sample_stb),
    .tx_real_in  (tx_real_in),
    .tx_imag_in  (tx_imag_in),
    .tx_real_out (tx_real_out),
    .tx_imag_out (tx_imag_out),
    .tx_key      (tx_key),
    .pa_enable   (pa_enable),
    .rx_mute     (rx_mute),
    .busy        (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    sample_stb = (phase == 3);
    phase = (phase + 1) % 4;
  endtask

  task automatic next_stb(output logic k);
    logic s;
    k = 1'b0;
    do begin
      k = tx_key;
      s = sample_stb;
      step();
    end while (!s);
  endtask

  task automatic wait_for(input bit sel, input logic v, output logic ok);
    int n;
    n = 0;
    while (((sel ? busy : tx_key) !== v) && n < 40) begin
      step();
      n++;
    end
    ok = ((sel ? busy : tx_key) === v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if ({tx_key, pa_enable, rx_mute, busy} !== 4'b0000 || tx_real_out !== 16'sd0 || tx_imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_hold: flags=%b%b%b%b out=%0d/%0d, required all 0", tx_key, pa_enable, rx_mute, busy, tx_real_out, tx_imag_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({tx_key, pa_enable, rx_mute, busy} !== 4'b0000 || tx_real_out !== 16'sd0 || tx_imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_release: flags=%b%b%b%b out=%0d/%0d, required all 0", tx_key, pa_enable, rx_mute, busy, tx_real_out, tx_imag_out);
    end
  endtask

  task automatic test_key_down();
    logic k;
    logic signed [15:0] exp_r [6];
    exp_r = '{16'sd0, 16'sd250, 16'sd500, 16'sd750, 16'sd1000, 16'sd1000};
    key_req = 1'b1;
    repeat (2) step();
    checks++;
    if (pa_enable !== 1'b0) begin
      errors++;
      $display("FAIL sync_delay: pa_enable=%b 2 clk after key, required 0", pa_enable);
    end
    step();
    checks++;
    if ({pa_enable, rx_mute, busy, tx_key} !== 4'b1110) begin
      errors++;
      $display("FAIL settle_entry: pa/mute/busy/key=%b, required 1110", {pa_enable, rx_mute, busy, tx_key});
    end
    repeat (9) step();
    checks++;
    if (tx_key !== 1'b0) begin
      errors++;
      $display("FAIL settle_early: tx_key=%b at 9 clk, required 0", tx_key);
    end
    step();
    checks++;
    if (tx_key !== 1'b1) begin
      errors++;
      $display("FAIL settle_end: tx_key=%b at 10 clk, required 1", tx_key);
    end
    for (int i = 0; i < 6; i++) begin
      next_stb(k);
      checks++;
      if (k !== 1'b1 || tx_real_out !== exp_r[i] || tx_imag_out !== -exp_r[i]) begin
        errors++;
        $display("FAIL ramp_up[%0d]: key=%b out=%0d/%0d, required 1 %0d/%0d", i, k, tx_real_out, tx_imag_out, exp_r[i], -exp_r[i]);
      end
    end
    repeat (2) step();
    checks++;
    if (tx_real_out !== 16'sd1000 || tx_key !== 1'b1) begin
      errors++;
      $display("FAIL tx_hold: out=%0d key=%b, required 1000 1", tx_real_out, tx_key);
    end
  endtask

  task automatic test_key_up();
    logic k;
    logic signed [15:0] q [$];
    int n;
    key_req = 1'b0;
    n = 0;
    do begin
      next_stb(k);
      if (k) q.push_back(tx_real_out);
      n++;
    end while (tx_key && n < 12);
    checks++;
    if (tx_key !== 1'b0) begin
      errors++;
      $display("FAIL key_up_timeout: tx_key=%b after %0d strobes, required 0", tx_key, n);
    end
    checks++;
    if (q.size() < 4 || q[q.size()-4] !== 16'sd1000 || q[q.size()-3] !== 16'sd750 ||
        q[q.size()-2] !== 16'sd500 || q[q.size()-1] !== 16'sd250) begin
      errors++;
      $display("FAIL ramp_down_seq: %0d samples ending %0d, required ...1000,750,500,250", q.size(), q.size() > 0 ? q[q.size()-1] : 16'sd0);
    end
    checks++;
    if (pa_enable !== 1'b0 || rx_mute !== 1'b1 || busy !== 1'b1 || tx_imag_out !== -16'sd250) begin
      errors++;
      $display("FAIL release_entry: pa=%b mute=%b busy=%b imag=%0d, required 0 1 1 -250", pa_enable, rx_mute, busy, tx_imag_out);
    end
    repeat (9) step();
    checks++;
    if (busy !== 1'b1 || rx_mute !== 1'b1) begin
      errors++;
      $display("FAIL release_early: busy=%b mute=%b at 9 clk, required 1 1", busy, rx_mute);
    end
    step();
    checks++;
    if (busy !== 1'b0 || rx_mute !== 1'b0) begin
      errors++;
      $display("FAIL release_end: busy=%b mute=%b at 10 clk, required 0 0", busy, rx_mute);
    end
    next_stb(k);
    checks++;
    if (tx_real_out !== 16'sd0 || tx_imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL rx_zero: out=%0d/%0d, required 0/0", tx_real_out, tx_imag_out);
    end
  endtask

  task automatic test_reversal();
    logic k, ok;
    logic signed [15:0] q [$];
    int n;
    key_req = 1'b1;
    wait_for(1'b0, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rev_key_timeout: tx_key=%b, required 1", tx_key);
    end
    next_stb(k);
    next_stb(k);
    checks++;
    if (k !== 1'b1 || tx_real_out !== 16'sd250) begin
      errors++;
      $display("FAIL rev_second: key=%b out=%0d, required 1 250", k, tx_real_out);
    end
    key_req = 1'b0;
    n = 0;
    do begin
      next_stb(k);
      if (k) q.push_back(tx_real_out);
      n++;
    end while (tx_key && n < 12);
    checks++;
    if (q.size() != 2 || q[0] !== 16'sd500 || q[1] !== 16'sd250) begin
      errors++;
      $display("FAIL rev_seq: %0d samples first %0d, required 500,250", q.size(), q.size() > 0 ? q[0] : 16'sd0);
    end
    next_stb(k);
    checks++;
    if (tx_real_out !== 16'sd0 || tx_key !== 1'b0) begin
      errors++;
      $display("FAIL rev_zero: out=%0d key=%b, required 0 0", tx_real_out, tx_key);
    end
    wait_for(1'b1, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rev_idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_short_pulse();
    logic seen;
    key_req = 1'b1;
    repeat (3) step();
    key_req = 1'b0;
    checks++;
    if ({pa_enable, busy, tx_key} !== 3'b110) begin
      errors++;
      $display("FAIL pulse_settle: pa/busy/key=%b, required 110", {pa_enable, busy, tx_key});
    end
    seen = 1'b0;
    repeat (9) begin
      step();
      seen = seen | tx_key | (tx_real_out != 16'sd0);
    end
    checks++;
    if (pa_enable !== 1'b1) begin
      errors++;
      $display("FAIL pulse_settle_full: pa_enable=%b at 9 clk, required 1", pa_enable);
    end
    step();
    checks++;
    if ({pa_enable, rx_mute, busy, tx_key} !== 4'b0110) begin
      errors++;
      $display("FAIL pulse_release: pa/mute/busy/key=%b, required 0110", {pa_enable, rx_mute, busy, tx_key});
    end
    repeat (9) begin
      step();
      seen = seen | tx_key | (tx_real_out != 16'sd0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pulse_release_full: busy=%b at 9 clk, required 1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || seen !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end: busy=%b key_or_out_seen=%b, required 0 0", busy, seen);
    end
  endtask

  task automatic test_rekey_release();
    key_req = 1'b1;
    repeat (3) step();
    key_req = 1'b0;
    repeat (10) step();
    checks++;
    if (pa_enable !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rekey_release_entry: pa=%b busy=%b, required 0 1", pa_enable, busy);
    end
    repeat (3) step();
    key_req = 1'b1;
    repeat (6) step();
    checks++;
    if (pa_enable !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rekey_held: pa=%b busy=%b, required 0 1", pa_enable, busy);
    end
    step();
    checks++;
    if (pa_enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rekey_rx: pa=%b busy=%b, required 0 0", pa_enable, busy);
    end
    step();
    checks++;
    if (pa_enable !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rekey_settle: pa=%b busy=%b, required 1 1", pa_enable, busy);
    end
  endtask

  task automatic test_async_reset();
    logic k, ok;
    int n;
    wait_for(1'b0, 1'b1, ok);
    n = 0;
    do begin
      next_stb(k);
      n++;
    end while (tx_real_out !== 16'sd1000 && n < 8);
    checks++;
    if (!ok || tx_real_out !== 16'sd1000) begin
      errors++;
      $display("FAIL areset_reach_tx: key_ok=%b out=%0d, required 1 1000", ok, tx_real_out);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_key, pa_enable, rx_mute, busy} !== 4'b0000 || tx_real_out !== 16'sd0 || tx_imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL areset_immediate: flags=%b%b%b%b out=%0d/%0d, required all 0", tx_key, pa_enable, rx_mute, busy, tx_real_out, tx_imag_out);
    end
    key_req = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || tx_real_out !== 16'sd0) begin
      errors++;
      $display("FAIL areset_rx: busy=%b out=%0d, required 0 0", busy, tx_real_out);
    end
    tx_real_in = -16'sd1;
    tx_imag_in = 16'sd1;
    key_req = 1'b1;
    wait_for(1'b0, 1'b1, ok);
    next_stb(k);
    checks++;
    if (!ok || tx_real_out !== 16'sd0) begin
      errors++;
      $display("FAIL floor_gain0: key_ok=%b out=%0d, required 1 0", ok, tx_real_out);
    end
    next_stb(k);
    checks++;
    if (tx_real_out !== -16'sd1 || tx_imag_out !== 16'sd0) begin
      errors++;
      $display("FAIL floor_gain1: out=%0d/%0d, required -1/0", tx_real_out, tx_imag_out);
    end
    key_req = 1'b0;
    wait_for(1'b1, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL final_idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    key_req = 1'b0;
    sample_stb = 1'b0;
    tx_real_in = 16'sd1000;
    tx_imag_in = -16'sd1000;
    test_reset();
    test_key_down();
    test_key_up();
    test_reversal();
    test_short_pulse();
    test_rekey_release();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_keying_sequencer.md
Name: tx_keying_sequencer

Overview:
Sequences RX→TX→RX transitions between the keying sources (CW pin, s_rate[7]) and the Transmitter's baseband input. It mutes RX, closes the PA/TR relay, waits for the relay to settle, then linearly ramps the I2S TX samples in. Key-up reverses the sequence. Sits between the I2S module outputs (tx_real/tx_imag) and the Transmitter inputs, and replaces the raw keying signal to the Transmitter.

Parameters:
CLOCK_FREQ, 153600000, clk frequency in Hz; documentation and default-derivation only
RELAY_DELAY_CYCLES, 768000, relay settle/release time in clk cycles (5 ms at default)
RAMP_STEPS_LOG2, 6, ramp length = 2^RAMP_STEPS_LOG2 sample strobes (64)

Ports:
clk  in  1  single clock for the whole block
reset  in  1  asynchronous, active-high reset
key_req  in  1  asynchronous keying request (CW || s_rate[7]); synchronised internally
sample_stb  in  1  one-clk pulse per audio sample, already in clk domain
tx_real_in  in  16  signed I sample from I2S
tx_imag_in  in  16  signed Q sample from I2S
tx_real_out  out  16  signed ramped I to Transmitter
tx_imag_out  out  16  signed ramped Q to Transmitter
tx_key  out  1  key to Transmitter; high in RAMP_UP, TX, RAMP_DOWN
pa_enable  out  1  TR/PA relay drive
rx_mute  out  1  receiver mute
busy  out  1  high in any state except RX

Behaviour:
- Reset (async): state RX; all outputs 0; gain=0; delay counter=0; synchroniser flops=0.
- key_req passes a 2-flop synchroniser; key_s is valid 2 clk after an edge. Only key_s is used below.
- States and outputs:
  RX: all outputs 0.
  SETTLE: rx_mute=1, pa_enable=1, tx_key=0.
  RAMP_UP: rx_mute=1, pa_enable=1, tx_key=1.
  TX: rx_mute=1, pa_enable=1, tx_key=1.
  RAMP_DOWN: rx_mute=1, pa_enable=1, tx_key=1.
  RELEASE: rx_mute=1, pa_enable=0, tx_key=0.
- Transitions:
  RX→SETTLE on key_s=1; counter loads 0.
  SETTLE: counter increments each clk. At counter==RELAY_DELAY_CYCLES-1 → RAMP_UP if key_s=1, else RELEASE. An early key-up does not abort the settle.
  RAMP_UP: gain+=1 per sample_stb. When gain reaches 2^L → TX. If key_s=0 → RAMP_DOWN, keeping the current gain.
  TX→RAMP_DOWN on key_s=0.
  RAMP_DOWN: gain-=1 per sample_stb. When gain==0 → RELEASE with counter cleared. If key_s=1 → RAMP_UP, keeping the current gain.
  RELEASE: counter counts to RELAY_DELAY_CYCLES-1, then → RX. key_s is ignored; this enforces minimum relay off time. A held key re-enters SETTLE on the cycle after RX.
- Arithmetic:
  L=RAMP_STEPS_LOG2; gain is unsigned, L+1 bits, range 0..2^L.
  out = (in * {1'b0,gain}) >>> L, computed as a signed 17+L-bit product.
  gain=2^L gives out==in exactly; gain=0 gives 0. No saturation is needed.
  Truncation is arithmetic shift (floor); e.g. -1*1>>>L = -1.
- Output timing:
  Outputs update only on sample_stb, registered: new sample value appears 1 clk after the strobe and is held between strobes.
  The gain used is the value before that strobe's increment/decrement.
  Outside RAMP_UP/TX/RAMP_DOWN, outputs are forced to 0 on the next sample_stb.
- Simultaneous events:
  sample_stb on the RAMP_UP→TX or RAMP_DOWN→RELEASE edge: the strobe uses the old gain and the state changes the same cycle.
  A key_s toggle and a strobe in the same cycle: the direction change applies first, and that strobe steps gain in the new direction.
- Counter width: $clog2(RELAY_DELAY_CYCLES+1); never wraps.
- Reset mid-operation immediately drops pa_enable/tx_key/rx_mute to 0. Relay timing is then the reset source's responsibility.

Decomposition:
- Shared transceiver package/header holds the state encoding localparams (RX, SETTLE, RAMP_UP, TX, RAMP_DOWN, RELEASE; 3-bit) and the TX sample width (16).
- One sub-module, ramp_gain_mult: registered signed 16×(L+1) multiply and shift for both I and Q, enabled by sample_stb.
- FSM, counter and synchroniser remain in tx_keying_sequencer.

Test Plan:
Bench parameters: RELAY_DELAY_CYCLES=10, RAMP_STEPS_LOG2=2, sample_stb every 4 clk, tx_real_in=16'sd1000, tx_imag_in=-16'sd1000.
1. Key-down held: pa_enable rises 3 clk after key_req; tx_key rises 10 clk later; tx_real_out steps 0, 250, 500, 750, 1000, then holds 1000 (imag mirrored negative).
2. Key-up from TX: outputs step 1000, 750, 500, 250, 0; tx_key falls when gain hits 0; pa_enable low; rx_mute and busy fall 10 clk later.
3. Key released after the 2nd ramp-up strobe: gain reverses from 2, outputs 500, 250, 0, with no TX state visited.
4. Key pulse of 3 clk in RX: SETTLE completes all 10 clk, RELEASE 10 clk, tx_key never asserted, outputs stay 0.
5. Key re-asserted during RELEASE: remains in RELEASE until RX, then re-enters SETTLE the next cycle.
6. Async reset asserted during TX: all outputs 0 without a clock edge; state RX after release; -1 input at gain 1 yields -1 (floor) on the next run.
